// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the RV32M multiply/divide controller: funct3 op codes,
// FSM states and the iteration count.
package mdu_ctrl_pkg;

   localparam int unsigned MDU_ITERS = 32;

   typedef enum logic [2:0] {
      MDUOp_MUL    = 3'b000,
      MDUOp_MULH   = 3'b001,
      MDUOp_MULHSU = 3'b010,
      MDUOp_MULHU  = 3'b011,
      MDUOp_DIV    = 3'b100,
      MDUOp_DIVU   = 3'b101,
      MDUOp_REM    = 3'b110,
      MDUOp_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_RUN,
      MDU_FIXUP,
      MDU_DONE
   } mdu_state_e;

   function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// divide step on a 64-bit {hi, lo} accumulator.
module mdu_step (
   input  logic        i_is_div,
   input  logic [63:0] i_acc,
   input  logic [31:0] i_mcand,
   output logic [63:0] o_acc
);

   logic [32:0] w_sum;
   logic [31:0] w_diff;
   logic        w_ge;

   always_comb begin
      w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_mcand} : 33'd0);
      // Shifted remainder is 33 bits; bit 63 set means it already exceeds any divisor.
      w_ge   = i_acc[63] | (i_acc[62:31] >= i_mcand);
      w_diff = i_acc[62:31] - i_mcand;
      if (i_is_div) begin
         if (w_ge) o_acc = {w_diff, i_acc[30:0], 1'b1};
         else      o_acc = {i_acc[62:0], 1'b0};
      end else begin
         o_acc = {w_sum, i_acc[31:1]};
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide controller: 32-step sequence with pipeline
// stall, divide-by-zero / overflow fast paths and flush abort.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic [XLEN-1:0] C,
   output logic            done,
   output logic            busy,
   output logic            stall
);

   mdu_state_e r_state;
   mdu_op_e    r_op;
   logic [63:0] r_acc;
   logic [31:0] r_mcand;
   logic [4:0]  r_cnt;
   logic        r_sa, r_sb, r_fast;

   mdu_op_e     w_op;
   logic        w_sa, w_sb, w_div0, w_ovf;
   logic [31:0] w_fast_res, w_quo, w_rem, w_result;
   logic [63:0] w_prod, w_step;

   mdu_step u_step (
      .i_is_div (r_op[2]),
      .i_acc    (r_acc),
      .i_mcand  (r_mcand),
      .o_acc    (w_step)
   );

   always_comb begin
      w_op   = mdu_op_e'(op);
      w_sa   = A[31] & (w_op inside {MDUOp_MULH, MDUOp_MULHSU, MDUOp_DIV, MDUOp_REM});
      w_sb   = B[31] & (w_op inside {MDUOp_MULH, MDUOp_DIV, MDUOp_REM});
      w_div0 = op[2] & (B == '0);
      w_ovf  = (w_op == MDUOp_DIV || w_op == MDUOp_REM) &&
               (A == 32'h8000_0000) && (B == '1);
      w_fast_res = '0;
      if (w_div0)     w_fast_res = op[1] ? A : '1;
      else if (w_ovf) w_fast_res = op[1] ? '0 : 32'h8000_0000;
   end

   always_comb begin
      w_prod = (r_sa ^ r_sb) ? (~r_acc + 64'd1) : r_acc;
      w_quo  = mdu_abs(r_acc[31:0], r_sa ^ r_sb);
      w_rem  = mdu_abs(r_acc[63:32], r_sa);
      w_result = '0;
      if (r_fast) begin
         w_result = r_acc[31:0];
      end else begin
         case (r_op)
            MDUOp_MUL:                             w_result = w_prod[31:0];
            MDUOp_MULH, MDUOp_MULHSU, MDUOp_MULHU: w_result = w_prod[63:32];
            MDUOp_DIV, MDUOp_DIVU:                 w_result = w_quo;
            default:                               w_result = w_rem;
         endcase
      end
   end

   always_comb begin
      stall = rstn & ((start & ~flush & (r_state == MDU_IDLE || r_state == MDU_DONE)) |
                      (r_state == MDU_RUN) | (r_state == MDU_FIXUP));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= MDU_IDLE;
         r_op    <= MDUOp_MUL;
         r_acc   <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_fast  <= 1'b0;
         C       <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            r_state <= MDU_IDLE;
            busy    <= 1'b0;
         end else begin
            case (r_state)
               MDU_IDLE, MDU_DONE: begin
                  if (start) begin
                     r_op    <= w_op;
                     r_sa    <= w_sa;
                     r_sb    <= w_sb;
                     r_cnt   <= '0;
                     r_mcand <= mdu_abs(B, w_sb);
                     busy    <= 1'b1;
                     // Fast-path result is parked in the accumulator and passed through FIXUP.
                     if (w_div0 || w_ovf) begin
                        r_acc   <= {32'd0, w_fast_res};
                        r_fast  <= 1'b1;
                        r_state <= MDU_FIXUP;
                     end else begin
                        r_acc   <= {32'd0, mdu_abs(A, w_sa)};
                        r_fast  <= 1'b0;
                        r_state <= MDU_RUN;
                     end
                  end else begin
                     r_state <= MDU_IDLE;
                     busy    <= 1'b0;
                  end
               end
               MDU_RUN: begin
                  r_acc <= w_step;
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'(MDU_ITERS - 1)) r_state <= MDU_FIXUP;
               end
               default: begin
                  C       <= w_result;
                  done    <= 1'b1;
                  r_state <= MDU_DONE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus queues expected results and done
// cycles, a negedge monitor pops and compares on every done pulse.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk, rstn, start, flush;
   logic [2:0]  op;
   logic [31:0] A, B, C;
   logic        done, busy, stall;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] c;
      int          cyc;
   } exp_t;
   exp_t q[$];
   exp_t e;

   typedef struct {
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t tbl[14] = '{
      '{MDUOp_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 2},
      '{MDUOp_REM,    32'd5,          32'd0,          32'd5,         2},
      '{MDUOp_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 2},
      '{MDUOp_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         2},
      '{MDUOp_DIV,    32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF, 2},
      '{MDUOp_REMU,   32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 2},
      '{MDUOp_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 34},
      '{MDUOp_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 34},
      '{MDUOp_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 34},
      '{MDUOp_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34},
      '{MDUOp_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34},
      '{MDUOp_DIVU,   32'd100,        32'd7,          32'd14,        34},
      '{MDUOp_MUL,    32'hFFFF_FFF0,  32'd3,          32'hFFFF_FFD0, 34},
      '{MDUOp_REMU,   32'd100,        32'd7,          32'd2,         34}
   };

   mdu_ctrl #(.XLEN(32)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .flush (flush),
      .C     (C),
      .done  (done),
      .busy  (busy),
      .stall (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && done) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done with C=%h at cycle %0d, required no done", C, cyc);
         end else begin
            e = q.pop_front();
            check("result", C, e.c);
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat, input bit push, output int t0);
      start = 1'b1; op = o; A = a; B = b;
      t0 = cyc;
      if (push) q.push_back('{r, cyc + lat});
      @(negedge clk);
      check("stall_start", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
   endtask

   task automatic goto_cycle(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle();
      @(posedge clk);
      for (int i = 0; i < 80 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout: got %0d pending results, required 0", q.size());
         q.delete();
      end
      #1;
   endtask

   logic [31:0] last_c;
   int t0, t1;

   initial begin
      rstn = 1'b1; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;
      #1 rstn = 1'b0; start = 1'b1;
      #2;
      check("reset_C", C, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      repeat (2) @(posedge clk);
      start = 1'b0;
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;

      // MUL with full busy/stall profile
      issue(MDUOp_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1, t0);
      for (int k = 1; k <= 35; k++) begin
         @(negedge clk);
         check("busy_profile", {31'd0, busy}, (k <= 34) ? 32'd1 : 32'd0);
         check("stall_profile", {31'd0, stall}, (k <= 33) ? 32'd1 : 32'd0);
      end
      wait_idle();
      last_c = 32'hFFFF_FFEB;

      foreach (tbl[i]) begin
         issue(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat, 1'b1, t0);
         wait_idle();
         last_c = tbl[i].r;
      end

      // Flush in cycle 10 of a DIV, then a fresh MUL in cycle 12
      issue(MDUOp_DIV, 32'd1000, 32'd3, 32'd0, 0, 1'b0, t0);
      goto_cycle(t0 + 10);
      flush = 1'b1;
      goto_cycle(t0 + 11);
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_C", C, last_c);
      goto_cycle(t0 + 12);
      issue(MDUOp_MUL, 32'd3, 32'd4, 32'd12, 34, 1'b1, t1);
      wait_idle();
      last_c = 32'd12;

      // Start during RUN is ignored
      issue(MDUOp_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1, t0);
      goto_cycle(t0 + 5);
      start = 1'b1; op = MDUOp_MUL; A = 32'd1; B = 32'd1;
      goto_cycle(t0 + 6);
      start = 1'b0;
      wait_idle();

      // Back-to-back start in the DONE cycle
      issue(MDUOp_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b1, t0);
      goto_cycle(t0 + 34);
      issue(MDUOp_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1, t1);
      wait_idle();

      // Asynchronous reset mid-operation
      issue(MDUOp_DIV, 32'hFFFF_FF00, 32'd3, 32'd0, 0, 1'b0, t0);
      goto_cycle(t0 + 20);
      rstn = 1'b0;
      #1;
      check("midreset_C", C, 32'd0);
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_stall", {31'd0, stall}, 32'd0);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      issue(MDUOp_MUL, 32'd3, 32'd4, 32'd12, 34, 1'b1, t0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative RV32M multiply/divide controller sitting beside the EX-stage ALU of the pipelined CPU. It accepts one M-extension operation from EX, holds the pipeline with a stall request while it runs a 32-step shift-add or restoring-divide sequence, and returns a 32-bit result on a one-cycle done pulse. Divide-by-zero and signed overflow take a fast path, and a flush input aborts any operation in flight.

## Interface
Parameters:
- `XLEN`, 32, operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request from EX. Sampled only in IDLE or DONE.
- `op`  in  3  `MDUOp_*` code, equal to instruction funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- `A`  in  32  rs1 operand. Must stay stable only in the start cycle.
- `B`  in  32  rs2 operand. Must stay stable only in the start cycle.
- `flush`  in  1  synchronous abort from hazard/branch logic.
- `C`  out  32  result register. Held until the next completion.
- `done`  out  1  one-cycle pulse. `C` is valid in this cycle.
- `busy`  out  1  registered; high when state is not IDLE.
- `stall`  out  1  combinational pipeline hold request.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE or DONE with `start=1` and `flush=0`:
  - Latch `op`.
  - Latch operand magnitudes and sign flags:
    - A is treated as signed for MULH, MULHSU, DIV and REM.
    - B is treated as signed for MULH, DIV and REM.
  - Clear the 5-bit iteration counter.
  - Go to RUN, except for the fast paths, which go to FIXUP.
- Fast paths (no iterations):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
- RUN, multiply:
  - Each cycle, conditionally add the multiplicand to the upper half of a 64-bit accumulator.
  - Shift right by 1.
  - After 32 steps the accumulator holds the unsigned 64-bit product of the magnitudes.
- RUN, divide:
  - Each cycle, shift {remainder, quotient} left by 1 and trial-subtract the divisor magnitude.
  - If the difference is non-negative, keep it and set quotient bit 0.
- RUN lasts exactly 32 cycles; the counter wraps 31→0, then the state goes to FIXUP.
- FIXUP:
  - Apply signs. The product is negated when sA^sB for signed variants. The quotient is negated when sA^sB. The remainder takes the sign of A.
  - Select the result: MUL takes the low word; MULH* take the high word.
  - Write `C` and go to DONE.
- DONE: `done=1`, then go to IDLE. A new `start` in DONE is accepted, giving back-to-back operation.
- `stall = (start & (IDLE|DONE) & ~flush) | RUN | FIXUP`. `stall` is low in DONE so EX advances and captures `C`.
- `flush=1` in any state: go to IDLE at the next edge. No `done`, `C` unchanged, any concurrent `start` ignored.
- `start` while in RUN or FIXUP: ignored.

## Timing
- Reset (`rstn=0`, asynchronous, any state): state IDLE, `C=0`, `done=0`, `busy=0`, counter 0. `stall` follows `start` only after reset is released.
- Cycle numbering: cycle 0 is the cycle with `start` high; the edge ending cycle 0 accepts it.
- Iterative operations:
  - RUN occupies cycles 1–32.
  - FIXUP is cycle 33.
  - `done` is high in cycle 34; latency is 34 cycles.
  - `busy` is high in cycles 1–34.
- Fast paths: FIXUP in cycle 1, `done` in cycle 2.
- Back-to-back: `start` in a DONE cycle gives a second `done` 34 cycles later with no idle gap.
- `flush` high in cycle k (1≤k≤34): `busy` low from cycle k+1; no `done` in or after cycle k+1.
- `rstn` deasserted mid-operation: the operation is lost, and the first accepted `start` behaves as from IDLE.

## Structure
- Add to the shared `ctrl_encode_def.v`:
  - `MDUOp_*` codes.
  - State encodings `MDU_IDLE`/`RUN`/`FIXUP`/`DONE`.
  - `MDU_ITERS` (32).
- One combinational sub-module is natural: `mdu_step`, a single shift-add / trial-subtract iteration selected by a mul/div flag.
- FSM, counter, sign fixup and result register stay in `mdu_ctrl`.

## Test plan
- MUL A=7, B=0xFFFFFFFD → `C=0xFFFFFFEB`, `done` only in cycle 34, `stall` high cycles 0–33.
- MULH A=B=0x80000000 → 0x40000000. MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast paths, each with `done` in cycle 2:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- `flush` in cycle 10 of a DIV:
  - `busy` low in cycle 11, no `done`, `C` unchanged.
  - A new MUL 3×4 started in cycle 12 → 12, with `done` in cycle 46.
- Mid-operation events:
  - `rstn` pulsed low in cycle 20 → all outputs 0 immediately.
  - `start` during RUN → ignored.
  - Back-to-back `start` in the DONE cycle → second result 34 cycles later.
